// File: rtl/lane_align_ctrl_pkg.sv
// Shared encodings for the two-lane alignment controller: FSM states,
// pair classes and the default alignment marker.
package lane_align_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RECOVER = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_SYNC = 2'd0,
    PC_DATA = 2'd1,
    PC_IDLE = 2'd2,
    PC_SKEW = 2'd3
  } pair_class_e;

  localparam logic [31:0] DEF_SYNC_WORD = 32'hBCBC_BCBC;

  // Run counters only ever hold limit-1, so a limit of 1 still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/lane_align_ctrl_if.sv
// Lane inputs and unstriper control outputs of the alignment controller.
// master drives the lanes, slave is the controller.
interface lane_align_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] lane_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_0;
  logic              valid_1;
  logic              sel;
  logic              unstripe_en;
  logic              aligned;
  logic [2:0]        state;
  logic              skew_err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output lane_0, lane_1, valid_0, valid_1,
    input  sel, unstripe_en, aligned, state, skew_err, err_cnt
  );

  modport slave (
    input  lane_0, lane_1, valid_0, valid_1,
    output sel, unstripe_en, aligned, state, skew_err, err_cnt
  );
endinterface

// File: rtl/lane_pair_classifier.sv
// Combinational classification of one lane pair into SYNC / DATA / IDLE / SKEW.
module lane_pair_classifier
  import lane_align_ctrl_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic [DATA_W-1:0] lane_0,
  input  logic [DATA_W-1:0] lane_1,
  input  logic              valid_0,
  input  logic              valid_1,
  output pair_class_e       pair_class
);

  logic sync_0_s;
  logic sync_1_s;

  assign sync_0_s = (lane_0 == SYNC_WORD);
  assign sync_1_s = (lane_1 == SYNC_WORD);

  // A marker on only one lane means the lanes are skewed against each other.
  always_comb begin
    pair_class = PC_SKEW;
    if (valid_0 && valid_1) begin
      if (sync_0_s && sync_1_s) begin
        pair_class = PC_SYNC;
      end else if (!sync_0_s && !sync_1_s) begin
        pair_class = PC_DATA;
      end else begin
        pair_class = PC_SKEW;
      end
    end else if (!valid_0 && !valid_1) begin
      pair_class = PC_IDLE;
    end else begin
      pair_class = PC_SKEW;
    end
  end

endmodule

// File: rtl/lane_align_ctrl.sv
// Two-lane alignment controller: acquires alignment from a run of sync pairs,
// drives the unstriper selector/enable and drops alignment on persistent skew.
module lane_align_ctrl
  import lane_align_ctrl_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int                SYNC_CNT  = 4,
  parameter int                ERR_MAX   = 3,
  parameter int                CNT_W     = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              enable_in,
  lane_align_ctrl_if.slave  bus
);

  localparam int SR_W = cnt_width(SYNC_CNT);
  localparam int BR_W = cnt_width(ERR_MAX);
  localparam logic [SR_W-1:0] SYNC_LAST = SR_W'(SYNC_CNT - 1);
  localparam logic [BR_W-1:0] BAD_LAST  = BR_W'(ERR_MAX - 1);

  pair_class_e      pair_class_s;
  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [SR_W-1:0]  sync_run_q, sync_run_d;
  logic [BR_W-1:0]  bad_run_q, bad_run_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             unstripe_en_q, unstripe_en_d;
  logic             skew_err_q, skew_err_d;
  logic             aligned_q, aligned_d;

  lane_pair_classifier #(
    .DATA_W    (DATA_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_classifier (
    .lane_0     (bus.lane_0),
    .lane_1     (bus.lane_1),
    .valid_0    (bus.valid_0),
    .valid_1    (bus.valid_1),
    .pair_class (pair_class_s)
  );

  // FSM state register
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and run/error counters; pairs are only judged in phase 0,
  // but a dropped enable takes effect on any edge.
  always_comb begin
    state_d    = state_q;
    sync_run_d = sync_run_q;
    bad_run_d  = bad_run_q;
    err_cnt_d  = err_cnt_q;
    phase_d    = ~phase_q;
    if (!enable_in) begin
      state_d    = ST_IDLE;
      sync_run_d = '0;
      bad_run_d  = '0;
    end else if (!phase_q) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (pair_class_s != PC_SYNC) begin
            sync_run_d = '0;
          end else if (sync_run_q == SYNC_LAST) begin
            state_d    = ST_ACTIVE;
            sync_run_d = '0;
          end else begin
            sync_run_d = sync_run_q + SR_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (pair_class_s != PC_SKEW) begin
            bad_run_d = '0;
          end else begin
            if (err_cnt_q != {CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
            if (bad_run_q == BAD_LAST) begin
              state_d   = ST_RECOVER;
              bad_run_d = '0;
            end else begin
              bad_run_d = bad_run_q + BR_W'(1);
            end
          end
        end
        ST_RECOVER: begin
          state_d = ST_SEARCH;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Control outputs, held across both cycles of a pair
  always_comb begin
    unstripe_en_d = unstripe_en_q;
    skew_err_d    = skew_err_q;
    aligned_d     = (state_d == ST_ACTIVE);
    if (!enable_in) begin
      unstripe_en_d = 1'b0;
      skew_err_d    = 1'b0;
    end else if (!phase_q) begin
      unstripe_en_d = (state_q == ST_ACTIVE) && (pair_class_s == PC_DATA);
      skew_err_d    = (state_q == ST_ACTIVE) && (pair_class_s == PC_SKEW);
    end else begin
      unstripe_en_d = unstripe_en_q;
      skew_err_d    = skew_err_q;
    end
  end

  // Phase, counters and registered outputs
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      phase_q       <= 1'b0;
      sync_run_q    <= '0;
      bad_run_q     <= '0;
      err_cnt_q     <= '0;
      unstripe_en_q <= 1'b0;
      skew_err_q    <= 1'b0;
      aligned_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      sync_run_q    <= sync_run_d;
      bad_run_q     <= bad_run_d;
      err_cnt_q     <= err_cnt_d;
      unstripe_en_q <= unstripe_en_d;
      skew_err_q    <= skew_err_d;
      aligned_q     <= aligned_d;
    end
  end

  assign bus.sel         = phase_q;
  assign bus.unstripe_en = unstripe_en_q;
  assign bus.aligned     = aligned_q;
  assign bus.state       = state_q;
  assign bus.skew_err    = skew_err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_lane_align_ctrl.sv
// Scoreboard bench for lane_align_ctrl: stimulus queues expected output tuples
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_lane_align_ctrl;

  localparam logic [31:0] SW = 32'hBCBC_BCBC;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [14:0] val;
  } exp_t;

  logic clk_2f = 1'b0;
  logic reset_L;
  logic en_a, en_b;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t m_e;
  logic [14:0] m_act;

  lane_align_ctrl_if #(.DATA_W(32), .CNT_W(8)) if_a ();
  lane_align_ctrl_if #(.DATA_W(32), .CNT_W(2)) if_b ();

  lane_align_ctrl #(.DATA_W(32), .SYNC_WORD(SW), .SYNC_CNT(4), .ERR_MAX(3), .CNT_W(8)) dut_a (
    .clk_2f(clk_2f), .reset_L(reset_L), .enable_in(en_a), .bus(if_a));
  lane_align_ctrl #(.DATA_W(32), .SYNC_WORD(SW), .SYNC_CNT(4), .ERR_MAX(3), .CNT_W(2)) dut_b (
    .clk_2f(clk_2f), .reset_L(reset_L), .enable_in(en_b), .bus(if_b));

  always #5 clk_2f = ~clk_2f;

  always @(posedge clk_2f) cyc <= cyc + 1;

  // val = {sel, unstripe_en, aligned, state[2:0], skew_err, err_cnt[7:0]}
  task automatic push(input int c, input int d, input string nm, input logic sel,
                      input logic un, input logic al, input logic [2:0] st,
                      input logic sk, input logic [7:0] err);
    exp_t e;
    e.cyc  = c;
    e.dut  = d;
    e.name = nm;
    e.val  = {sel, un, al, st, sk, err};
    q.push_back(e);
  endtask

  // Drive one pair in its phase-0 cycle; expect the result mid phase 1,
  // and optionally that it still holds through the next phase-0 cycle.
  task automatic pair(input int d, input logic en, input logic [31:0] l0, input logic [31:0] l1,
                      input logic v0, input logic v1, input string nm, input logic un,
                      input logic al, input logic [2:0] st, input logic sk,
                      input logic [7:0] err, input bit hold);
    @(negedge clk_2f);
    if (d == 0) begin
      en_a = en; if_a.lane_0 = l0; if_a.lane_1 = l1; if_a.valid_0 = v0; if_a.valid_1 = v1;
    end else begin
      en_b = en; if_b.lane_0 = l0; if_b.lane_1 = l1; if_b.valid_0 = v0; if_b.valid_1 = v1;
    end
    push(cyc + 1, d, nm, 1'b1, un, al, st, sk, err);
    if (hold) push(cyc + 2, d, {nm, "_hold"}, 1'b0, un, al, st, sk, err);
    @(negedge clk_2f);
  endtask

  // Monitor: compare every expectation that falls due on this negedge
  always @(negedge clk_2f) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      if (m_e.dut == 0)
        m_act = {if_a.sel, if_a.unstripe_en, if_a.aligned, if_a.state, if_a.skew_err, if_a.err_cnt};
      else
        m_act = {if_b.sel, if_b.unstripe_en, if_b.aligned, if_b.state, if_b.skew_err, 6'd0, if_b.err_cnt};
      total = total + 1;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        bad = bad + 1;
        $display("FAIL %s dut=%0d cyc=%0d due=%0d got sel/un/al/st/sk/err=%b/%b/%b/%0d/%b/%0d required %b/%b/%b/%0d/%b/%0d",
                 m_e.name, m_e.dut, cyc, m_e.cyc,
                 m_act[14], m_act[13], m_act[12], m_act[11:9], m_act[8], m_act[7:0],
                 m_e.val[14], m_e.val[13], m_e.val[12], m_e.val[11:9], m_e.val[8], m_e.val[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset_L = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    if_a.lane_0 = SW; if_a.lane_1 = D1; if_a.valid_0 = 1'b1; if_a.valid_1 = 1'b1;
    if_b.lane_0 = 32'd0; if_b.lane_1 = 32'd0; if_b.valid_0 = 1'b0; if_b.valid_1 = 1'b0;
    repeat (2) @(posedge clk_2f);
    #2;
    push(cyc, 0, "reset_a", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
    push(cyc, 1, "reset_b", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
    @(posedge clk_2f);
    #1 reset_L = 1'b1;

    // Acquisition: IDLE -> SEARCH, four sync pairs -> ACTIVE, then data
    pair(0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, "idle_to_search", 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      pair(0, 1'b1, SW, SW, 1'b1, 1'b1, "sync_run", 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0);
    pair(0, 1'b1, SW, SW, 1'b1, 1'b1, "sync_4th", 1'b0, 1'b1, 3'd2, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++)
      pair(0, 1'b1, D1, D2, 1'b1, 1'b1, "data_en", 1'b1, 1'b1, 3'd2, 1'b0, 8'd0, 1'b1);

    // Isolated skews separated by data never reach ERR_MAX
    pair(0, 1'b1, D1, D2, 1'b1, 1'b0, "skew_v0only", 1'b0, 1'b1, 3'd2, 1'b1, 8'd1, 1'b1);
    pair(0, 1'b1, D1, D2, 1'b1, 1'b1, "data_after_skew1", 1'b1, 1'b1, 3'd2, 1'b0, 8'd1, 1'b0);
    pair(0, 1'b1, SW, D2, 1'b1, 1'b1, "skew_one_sync", 1'b0, 1'b1, 3'd2, 1'b1, 8'd2, 1'b0);
    pair(0, 1'b1, D1, D2, 1'b1, 1'b1, "data_after_skew2", 1'b1, 1'b1, 3'd2, 1'b0, 8'd2, 1'b0);
    pair(0, 1'b1, D1, D2, 1'b0, 1'b1, "skew_v1only", 1'b0, 1'b1, 3'd2, 1'b1, 8'd3, 1'b0);
    pair(0, 1'b1, D1, D2, 1'b1, 1'b1, "data_after_skew3", 1'b1, 1'b1, 3'd2, 1'b0, 8'd3, 1'b0);

    // Three consecutive skews -> RECOVER for one pair -> SEARCH
    pair(0, 1'b1, D1, D2, 1'b1, 1'b0, "skew_run1", 1'b0, 1'b1, 3'd2, 1'b1, 8'd4, 1'b0);
    pair(0, 1'b1, D1, SW, 1'b1, 1'b1, "skew_run2", 1'b0, 1'b1, 3'd2, 1'b1, 8'd5, 1'b0);
    pair(0, 1'b1, D1, D2, 1'b0, 1'b1, "skew_run3", 1'b0, 1'b0, 3'd3, 1'b1, 8'd6, 1'b0);
    pair(0, 1'b1, D1, D2, 1'b1, 1'b1, "recover_exit", 1'b0, 1'b0, 3'd1, 1'b0, 8'd6, 1'b0);

    // Broken sync run restarts the count
    for (int i = 0; i < 3; i++)
      pair(0, 1'b1, SW, SW, 1'b1, 1'b1, "sync_run_a", 1'b0, 1'b0, 3'd1, 1'b0, 8'd6, 1'b0);
    pair(0, 1'b1, D1, D2, 1'b1, 1'b1, "run_break", 1'b0, 1'b0, 3'd1, 1'b0, 8'd6, 1'b0);
    for (int i = 0; i < 3; i++)
      pair(0, 1'b1, SW, SW, 1'b1, 1'b1, "sync_run_b", 1'b0, 1'b0, 3'd1, 1'b0, 8'd6, 1'b0);
    pair(0, 1'b1, SW, SW, 1'b1, 1'b1, "sync_run_b4", 1'b0, 1'b1, 3'd2, 1'b0, 8'd6, 1'b0);
    pair(0, 1'b1, D1, D2, 1'b1, 1'b1, "data_realigned", 1'b1, 1'b1, 3'd2, 1'b0, 8'd6, 1'b0);

    // enable_in dropped in phase 1 -> IDLE on the very next edge
    en_a = 1'b0;
    push(cyc + 1, 0, "enable_drop", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd6);
    pair(0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, "enable_back", 1'b0, 1'b0, 3'd1, 1'b0, 8'd6, 1'b0);

    // Async reset mid-pair clears everything including err_cnt
    @(posedge clk_2f);
    #2 reset_L = 1'b0;
    en_a = 1'b0;
    push(cyc, 0, "async_reset_a", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
    @(posedge clk_2f);
    #1 reset_L = 1'b1;

    // Narrow err_cnt saturates at all-ones
    pair(1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, "b_idle_to_search", 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      pair(1, 1'b1, SW, SW, 1'b1, 1'b1, "b_sync_run", 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0);
    pair(1, 1'b1, SW, SW, 1'b1, 1'b1, "b_sync_4th", 1'b0, 1'b1, 3'd2, 1'b0, 8'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      pair(1, 1'b1, D1, D2, 1'b0, 1'b1, "b_skew", 1'b0, 1'b1, 3'd2, 1'b1,
           (i > 3) ? 8'd3 : 8'(i), 1'b0);
      pair(1, 1'b1, D1, D2, 1'b1, 1'b1, "b_data", 1'b1, 1'b1, 3'd2, 1'b0,
           (i > 3) ? 8'd3 : 8'(i), 1'b0);
    end

    // Reset asserted in phase 1 of a data pair: outputs drop before any edge
    @(negedge clk_2f);
    if_b.lane_0 = D1; if_b.lane_1 = D2; if_b.valid_0 = 1'b1; if_b.valid_1 = 1'b1;
    @(posedge clk_2f);
    #2 reset_L = 1'b0;
    push(cyc, 1, "b_async_reset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
    @(posedge clk_2f);
    #1 reset_L = 1'b1;
    pair(1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, "b_first_pair", 1'b0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0);

    repeat (4) @(posedge clk_2f);
    if (q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL pending_checks got %0d left required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
